// File: rtl/maxpool_layer_param.sv
// Streaming 2x2 / stride-2 max-pooling over a CH x DATA_W raster pixel stream, using a half-width line buffer.
// Define MAXPOOL_SIGNED_EN to treat channel samples as two's complement (signed max); default is unsigned.
module maxpool_layer_param #(
  parameter int CH     = 8,
  parameter int DATA_W = 1,
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [CH*DATA_W-1:0] data_in,
  output logic                 valid_out,
  output logic [CH*DATA_W-1:0] data_out,
  output logic                 frame_done
);
  // Handshake: valid_in qualifies data_in with no ready (the producer never stalls);
  // valid_out is a one-cycle strobe qualifying data_out, which holds between strobes.

  localparam int W      = CH * DATA_W;
  localparam int OUT_W  = IMG_W / 2;
  localparam int OUT_H  = IMG_H / 2;
  localparam int POOL_W = 2 * OUT_W;
  localparam int POOL_H = 2 * OUT_H;
  localparam int CW     = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW     = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LB_AW  = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  generate
    if (IMG_W < 2 || IMG_H < 2) begin : g_bad_geometry
      $error("maxpool_layer_param: IMG_W and IMG_H must both be at least 2");
    end
  endgenerate

  function automatic logic [W-1:0] vmax(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] res;
    res = '0;
    for (int k = 0; k < CH; k++) begin
`ifdef MAXPOOL_SIGNED_EN
      if ($signed(a[k*DATA_W +: DATA_W]) > $signed(b[k*DATA_W +: DATA_W]))
`else
      if (a[k*DATA_W +: DATA_W] > b[k*DATA_W +: DATA_W])
`endif
        res[k*DATA_W +: DATA_W] = a[k*DATA_W +: DATA_W];
      else
        res[k*DATA_W +: DATA_W] = b[k*DATA_W +: DATA_W];
    end
    return res;
  endfunction

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [W-1:0]     r_hold;
  logic [W-1:0]     r_linebuf [OUT_W];
  logic             r_valid_out;
  logic [W-1:0]     r_data_out;
  logic             r_frame_done;

  logic             w_last_col;
  logic             w_last_row;
  logic             w_in_pool;
  logic             w_lb_we;
  logic             w_emit;
  logic [LB_AW-1:0] w_lb_idx;
  logic [W-1:0]     w_pair;
  logic [W-1:0]     w_quad;

  assign w_last_col = (32'(r_col) == IMG_W - 1);
  assign w_last_row = (32'(r_row) == IMG_H - 1);
  // Trailing odd column/row fall outside the pooled region but still step the counters.
  assign w_in_pool  = (32'(r_col) < POOL_W) && (32'(r_row) < POOL_H);
  assign w_lb_idx   = LB_AW'(r_col >> 1);
  assign w_pair     = vmax(r_hold, data_in);
  assign w_quad     = vmax(r_linebuf[w_lb_idx], w_pair);
  assign w_lb_we    = valid_in && w_in_pool && r_col[0] && !r_row[0];
  assign w_emit     = valid_in && w_in_pool && r_col[0] && r_row[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (valid_in) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold       <= '0;
      r_valid_out  <= 1'b0;
      r_data_out   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out  <= w_emit;
      r_frame_done <= w_emit && (32'(r_row) == POOL_H - 1) && (32'(r_col) == POOL_W - 1);
      if (valid_in && w_in_pool && !r_col[0])
        r_hold <= data_in;
      if (w_emit)
        r_data_out <= w_quad;
    end
  end

  // Written on even rows, read on odd rows, so the same entry is never both in one cycle.
  always_ff @(posedge clk) begin
    if (w_lb_we)
      r_linebuf[w_lb_idx] <= w_pair;
  end

  assign valid_out  = r_valid_out;
  assign data_out   = r_data_out;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_maxpool_layer_param.sv
// Bench for maxpool_layer_param: a 4x4 binary instance and a 5x5 4-bit instance checked against a window-max model.
module tb_maxpool_layer_param;

  localparam int A_CH = 2, A_DW = 1, A_W = 4, A_H = 4;
  localparam int B_CH = 2, B_DW = 4, B_W = 5, B_H = 5;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_valid_in, a_valid_out, a_frame_done;
  logic [1:0] a_data_in, a_data_out;
  logic       b_valid_in, b_valid_out, b_frame_done;
  logic [7:0] b_data_in, b_data_out;

  maxpool_layer_param #(.CH(A_CH), .DATA_W(A_DW), .IMG_W(A_W), .IMG_H(A_H)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .valid_in(a_valid_in), .data_in(a_data_in),
    .valid_out(a_valid_out), .data_out(a_data_out), .frame_done(a_frame_done));

  maxpool_layer_param #(.CH(B_CH), .DATA_W(B_DW), .IMG_W(B_W), .IMG_H(B_H)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .valid_in(b_valid_in), .data_in(b_data_in),
    .valid_out(b_valid_out), .data_out(b_data_out), .frame_done(b_frame_done));

  logic [8:0] exp_a_q[$];
  logic [8:0] exp_b_q[$];
  logic [7:0] frame_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int a_vo_cnt = 0, b_vo_cnt = 0, a_fd_cnt = 0, b_fd_cnt = 0, a_cnt_mark = 0;
  logic a_fire, b_fire, a_prev_fire, b_prev_fire;
  logic [7:0] a_last, b_last, b_first;
  logic [8:0] e;
  logic final_req;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model
  function automatic logic [7:0] chmax(input logic [7:0] a, input logic [7:0] b, input int ch, input int dw);
    int va, vb, mask, res;
    res  = 0;
    mask = (1 << dw) - 1;
    for (int k = 0; k < ch; k++) begin
      va = (int'(a) >> (k * dw)) & mask;
      vb = (int'(b) >> (k * dw)) & mask;
`ifdef MAXPOOL_SIGNED_EN
      if (va > mask / 2) va = va - (mask + 1);
      if (vb > mask / 2) vb = vb - (mask + 1);
`endif
      res = res | (((va > vb) ? va : vb) & mask) << (k * dw);
    end
    return res[7:0];
  endfunction

  task automatic model_frame(input int which, input int w, input int h, input int ch, input int dw);
    int base;
    logic [7:0] m;
    logic [8:0] ent;
    for (int oy = 0; oy < h / 2; oy++) begin
      for (int ox = 0; ox < w / 2; ox++) begin
        base = (2 * oy) * w + 2 * ox;
        m = chmax(chmax(frame_q[base], frame_q[base + 1], ch, dw),
                  chmax(frame_q[base + w], frame_q[base + w + 1], ch, dw), ch, dw);
        ent = {(oy == h / 2 - 1) && (ox == w / 2 - 1), m};
        if (which == 0) exp_a_q.push_back(ent);
        else            exp_b_q.push_back(ent);
      end
    end
  endtask

  // driver tasks
  task automatic fill_rand(input int n, input int mask);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom_range(0, 255) & mask));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      a_valid_in = 1'b0; b_valid_in = 1'b0; a_fire = 1'b0; b_fire = 1'b0;
    end
  endtask

  task automatic drive_frame(input int which, input int w, input int h, input int npix, input int gap_pct);
    int r, c;
    logic f;
    logic [7:0] pix;
    for (int i = 0; i < npix; i++) begin
      while ($urandom_range(0, 99) < gap_pct) idle(1);
      r   = i / w;
      c   = i % w;
      f   = (r % 2 == 1) && (c % 2 == 1) && (c < 2 * (w / 2)) && (r < 2 * (h / 2));
      pix = frame_q[i];
      @(posedge clk); #1;
      if (which == 0) begin
        a_valid_in = 1'b1; a_data_in = pix[1:0]; a_fire = f;
      end else begin
        b_valid_in = 1'b1; b_data_in = pix; b_fire = f;
      end
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_a_valid", a_valid_out, 0);
      check("rst_a_data", a_data_out, 0);
      check("rst_a_done", a_frame_done, 0);
      check("rst_b_valid", b_valid_out, 0);
      check("rst_b_data", b_data_out, 0);
      check("rst_b_done", b_frame_done, 0);
      a_prev_fire = 1'b0; b_prev_fire = 1'b0;
      a_last = '0; b_last = '0;
    end else begin
      check("a_valid_timing", a_valid_out, a_prev_fire);
      if (a_valid_out) begin
        a_vo_cnt++;
        if (a_frame_done) a_fd_cnt++;
        if (exp_a_q.size() == 0) check("a_extra_output", a_valid_out, 0);
        else begin
          e = exp_a_q.pop_front();
          check("a_data", a_data_out, e[1:0]);
          check("a_frame_done", a_frame_done, e[8]);
          a_last = e[7:0];
        end
      end else begin
        check("a_hold", a_data_out, a_last);
        check("a_done_idle", a_frame_done, 0);
      end
      a_prev_fire = a_valid_in & a_fire;

      check("b_valid_timing", b_valid_out, b_prev_fire);
      if (b_valid_out) begin
        if (b_vo_cnt == 0) b_first = b_data_out;
        b_vo_cnt++;
        if (b_frame_done) b_fd_cnt++;
        if (exp_b_q.size() == 0) check("b_extra_output", b_valid_out, 0);
        else begin
          e = exp_b_q.pop_front();
          check("b_data", b_data_out, e[7:0]);
          check("b_frame_done", b_frame_done, e[8]);
          b_last = e[7:0];
        end
      end else begin
        check("b_hold", b_data_out, b_last);
        check("b_done_idle", b_frame_done, 0);
      end
      b_prev_fire = b_valid_in & b_fire;

      if (final_req) begin
        check("a_queue_drained", exp_a_q.size(), 0);
        check("b_queue_drained", exp_b_q.size(), 0);
        check("a_output_count", a_vo_cnt, 20);
        check("b_output_count", b_vo_cnt, 20);
        check("a_frame_done_count", a_fd_cnt, 5);
        check("b_frame_done_count", b_fd_cnt, 5);
        check("a_post_reset_count", a_vo_cnt - a_cnt_mark, 4);
`ifdef MAXPOOL_SIGNED_EN
        check("b_first_window", b_first, 8'h17);
`else
        check("b_first_window", b_first, 8'hF9);
`endif
        final_req = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; final_req = 1'b0;
    a_valid_in = 1'b0; a_data_in = '0; a_fire = 1'b0;
    b_valid_in = 1'b0; b_data_in = '0; b_fire = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // A: single set pixel at (1,1) ch0
    frame_q.delete();
    for (int i = 0; i < A_W * A_H; i++) frame_q.push_back(8'h00);
    frame_q[5] = 8'h01;
    model_frame(0, A_W, A_H, A_CH, A_DW);
    drive_frame(0, A_W, A_H, A_W * A_H, 0);
    idle(3);

    // A: continuous random frame
    fill_rand(A_W * A_H, 3);
    model_frame(0, A_W, A_H, A_CH, A_DW);
    drive_frame(0, A_W, A_H, A_W * A_H, 0);
    idle(2);

    // B: directed window, ch0 = 3,9,5,7 and ch1 = F,1,1,1
    frame_q.delete();
    for (int i = 0; i < B_W * B_H; i++) frame_q.push_back(8'h00);
    frame_q[0] = 8'hF3; frame_q[1] = 8'h19; frame_q[5] = 8'h15; frame_q[6] = 8'h17;
    model_frame(1, B_W, B_H, B_CH, B_DW);
    drive_frame(1, B_W, B_H, B_W * B_H, 0);
    idle(2);

    // B: only the ignored last row/column set, then a random frame straight after
    frame_q.delete();
    for (int i = 0; i < B_W * B_H; i++)
      frame_q.push_back((i / B_W == B_H - 1 || i % B_W == B_W - 1) ? 8'hFF : 8'h00);
    model_frame(1, B_W, B_H, B_CH, B_DW);
    drive_frame(1, B_W, B_H, B_W * B_H, 0);
    fill_rand(B_W * B_H, 255);
    model_frame(1, B_W, B_H, B_CH, B_DW);
    drive_frame(1, B_W, B_H, B_W * B_H, 0);
    idle(2);

    // back-to-back frames with ~50% input gaps
    for (int f = 0; f < 2; f++) begin
      fill_rand(A_W * A_H, 3);
      model_frame(0, A_W, A_H, A_CH, A_DW);
      drive_frame(0, A_W, A_H, A_W * A_H, 50);
    end
    idle(3);
    for (int f = 0; f < 2; f++) begin
      fill_rand(B_W * B_H, 255);
      model_frame(1, B_W, B_H, B_CH, B_DW);
      drive_frame(1, B_W, B_H, B_W * B_H, 50);
    end
    idle(3);

    // A: abort mid-row 1, then a full frame
    a_cnt_mark = a_vo_cnt;
    fill_rand(A_W * A_H, 3);
    drive_frame(0, A_W, A_H, A_W + 1, 0);
    idle(1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill_rand(A_W * A_H, 3);
    model_frame(0, A_W, A_H, A_CH, A_DW);
    drive_frame(0, A_W, A_H, A_W * A_H, 30);
    idle(3);

    @(posedge clk); #1;
    final_req = 1'b1;
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
